// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: op-vector bit positions, widths,
// divider state encoding and the store byte-enable helper.
package ex_stage_pkg;
  localparam int ALU_OP_W = 12;
  localparam int DIV_OP_W = 4;
  localparam int ST_OP_W  = 3;
  localparam int LD_W     = 5;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_NOR  = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam int DIV_W    = 0;
  localparam int DIV_WU   = 1;
  localparam int MOD_W    = 2;
  localparam int MOD_WU   = 3;

  localparam int ST_B     = 0;
  localparam int ST_H     = 1;
  localparam int ST_W     = 2;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [3:0] st_mask(input logic [ST_OP_W-1:0] st, input logic [1:0] a);
    if (st[ST_W]) return 4'b1111;
    if (st[ST_H]) return 4'b0011 << {a[1], 1'b0};
    if (st[ST_B]) return 4'b0001 << a;
    return 4'b0000;
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// Decode->execute handshake/payload, execute->memory payload and data SRAM port.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic                ms_allowin;
  logic                es_allowin;
  logic                ds_to_es_valid;
  logic [31:0]         ds_pc;
  logic [ALU_OP_W-1:0] ds_alu_op;
  logic [DIV_OP_W-1:0] ds_div_op;
  logic [31:0]         ds_alu_src1;
  logic [31:0]         ds_alu_src2;
  logic [ST_OP_W-1:0]  ds_st_op;
  logic [31:0]         ds_rkd_value;
  logic [LD_W-1:0]     ds_ld_inst;
  logic                ds_res_from_mem;
  logic                ds_rf_we;
  logic [4:0]          ds_rf_waddr;

  logic                es_to_ms_valid;
  logic [31:0]         es_pc;
  logic [31:0]         es_alu_result;
  logic                es_res_from_mem;
  logic                es_rf_we;
  logic [4:0]          es_rf_waddr;
  logic [LD_W-1:0]     es_ld_inst;
  logic                es_load_blk;

  logic                data_sram_en;
  logic [3:0]          data_sram_we;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;

  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_pc, ds_alu_op, ds_div_op, ds_alu_src1,
           ds_alu_src2, ds_st_op, ds_rkd_value, ds_ld_inst, ds_res_from_mem,
           ds_rf_we, ds_rf_waddr,
    output es_allowin, es_to_ms_valid, es_pc, es_alu_result, es_res_from_mem,
           es_rf_we, es_rf_waddr, es_ld_inst, es_load_blk,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output ms_allowin, ds_to_es_valid, ds_pc, ds_alu_op, ds_div_op, ds_alu_src1,
           ds_alu_src2, ds_st_op, ds_rkd_value, ds_ld_inst, ds_res_from_mem,
           ds_rf_we, ds_rf_waddr,
    input  es_allowin, es_to_ms_valid, es_pc, es_alu_result, es_res_from_mem,
           es_rf_we, es_rf_waddr, es_ld_inst, es_load_blk,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_div_unit.sv
// 32-iteration restoring radix-2 divider on magnitudes with sign fix-up on output.
// Operands are captured on start; results hold in DONE until acked.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);
  div_state_e  r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic        r_q_neg, r_r_neg, r_by_zero;

  logic        w_a_neg, w_b_neg, w_ge;
  logic [31:0] w_a_mag, w_b_mag, w_diff;
  logic [32:0] w_shift;

  assign w_a_neg = i_signed & i_dividend[31];
  assign w_b_neg = i_signed & i_divisor[31];
  assign w_a_mag = w_a_neg ? (32'd0 - i_dividend) : i_dividend;
  assign w_b_mag = w_b_neg ? (32'd0 - i_divisor)  : i_divisor;

  // Partial remainder stays below the divisor, so the 32-bit difference is exact when taken.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_diff  = w_shift[31:0] - r_dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DIV_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (i_start) w_next = DIV_BUSY;
      DIV_BUSY: if (r_cnt == 5'(DIV_ITERS - 1)) w_next = DIV_DONE;
      DIV_DONE: if (i_ack) w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_by_zero <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: if (i_start) begin
          r_cnt     <= '0;
          r_quo     <= w_a_mag;
          r_rem     <= '0;
          r_dvs     <= w_b_mag;
          r_q_neg   <= w_a_neg ^ w_b_neg;
          r_r_neg   <= w_a_neg;
          r_by_zero <= (i_divisor == 32'd0);
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + 5'd1;
          r_quo <= {r_quo[30:0], w_ge};
          r_rem <= w_ge ? w_diff : w_shift[31:0];
        end
        default: ;
      endcase
    end
  end

  // Divide-by-zero: quotient all ones; remainder is |dividend| re-signed, i.e. the dividend.
  assign o_quotient  = r_by_zero ? 32'hFFFF_FFFF : (r_q_neg ? (32'd0 - r_quo) : r_quo);
  assign o_remainder = r_r_neg ? (32'd0 - r_rem) : r_rem;
  assign o_busy      = (r_state == DIV_BUSY);
  assign o_done      = (r_state == DIV_DONE);
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, multi-cycle divider, and data SRAM request generation,
// with valid/allowin pipeline handshake towards decode and memory.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  ex_stage_if.slave  bus
);
  logic                r_es_valid;
  logic [31:0]         r_pc, r_src1, r_src2, r_rkd;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [DIV_OP_W-1:0] r_div_op;
  logic [ST_OP_W-1:0]  r_st_op;
  logic [LD_W-1:0]     r_ld_inst;
  logic                r_res_from_mem, r_rf_we;
  logic [4:0]          r_rf_waddr;

  logic        w_is_div, w_is_st, w_ready_go, w_allowin, w_sram_en;
  logic        w_div_busy, w_div_done;
  logic [31:0] w_div_q, w_div_r, w_alu, w_result;

  assign w_is_div   = |r_div_op;
  assign w_is_st    = |r_st_op;
  assign w_ready_go = !w_is_div | w_div_done;
  assign w_allowin  = !r_es_valid | (w_ready_go & bus.ms_allowin);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_es_valid <= 1'b0;
    else if (w_allowin) r_es_valid <= bus.ds_to_es_valid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc <= '0; r_src1 <= '0; r_src2 <= '0; r_rkd <= '0;
      r_alu_op <= '0; r_div_op <= '0; r_st_op <= '0; r_ld_inst <= '0;
      r_res_from_mem <= 1'b0; r_rf_we <= 1'b0; r_rf_waddr <= '0;
    end else if (bus.ds_to_es_valid && w_allowin) begin
      r_pc           <= bus.ds_pc;
      r_src1         <= bus.ds_alu_src1;
      r_src2         <= bus.ds_alu_src2;
      r_rkd          <= bus.ds_rkd_value;
      r_alu_op       <= bus.ds_alu_op;
      r_div_op       <= bus.ds_div_op;
      r_st_op        <= bus.ds_st_op;
      r_ld_inst      <= bus.ds_ld_inst;
      r_res_from_mem <= bus.ds_res_from_mem;
      r_rf_we        <= bus.ds_rf_we;
      r_rf_waddr     <= bus.ds_rf_waddr;
    end
  end

  always_comb begin
    w_alu = '0;
    if      (r_alu_op[ALU_ADD])  w_alu = r_src1 + r_src2;
    else if (r_alu_op[ALU_SUB])  w_alu = r_src1 - r_src2;
    else if (r_alu_op[ALU_SLT])  w_alu = {31'd0, $signed(r_src1) < $signed(r_src2)};
    else if (r_alu_op[ALU_SLTU]) w_alu = {31'd0, r_src1 < r_src2};
    else if (r_alu_op[ALU_AND])  w_alu = r_src1 & r_src2;
    else if (r_alu_op[ALU_OR])   w_alu = r_src1 | r_src2;
    else if (r_alu_op[ALU_NOR])  w_alu = ~(r_src1 | r_src2);
    else if (r_alu_op[ALU_XOR])  w_alu = r_src1 ^ r_src2;
    else if (r_alu_op[ALU_SLL])  w_alu = r_src1 << r_src2[4:0];
    else if (r_alu_op[ALU_SRL])  w_alu = r_src1 >> r_src2[4:0];
    else if (r_alu_op[ALU_SRA])  w_alu = $unsigned($signed(r_src1) >>> r_src2[4:0]);
    else if (r_alu_op[ALU_LUI])  w_alu = r_src2;
  end

  // The FSM only honours start from IDLE; the extra gating keeps a held divide from re-arming.
  div_unit u_div (
    .clk         (clk),
    .rst_n       (resetn),
    .i_start     (r_es_valid & w_is_div & !w_div_busy & !w_div_done),
    .i_signed    (r_div_op[DIV_W] | r_div_op[MOD_W]),
    .i_dividend  (r_src1),
    .i_divisor   (r_src2),
    .i_ack       (bus.ms_allowin),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  assign w_result = !w_is_div ? w_alu :
                    (r_div_op[MOD_W] | r_div_op[MOD_WU]) ? w_div_r : w_div_q;

  // Gating on ms_allowin makes the request fire only on the cycle the op leaves.
  assign w_sram_en = r_es_valid & (r_res_from_mem | w_is_st) & bus.ms_allowin;

  assign bus.es_allowin      = w_allowin;
  assign bus.es_to_ms_valid  = r_es_valid & w_ready_go;
  assign bus.es_pc           = r_pc;
  assign bus.es_alu_result   = w_result;
  assign bus.es_res_from_mem = r_res_from_mem;
  assign bus.es_rf_we        = r_es_valid & r_rf_we;
  assign bus.es_rf_waddr     = r_rf_waddr;
  assign bus.es_ld_inst      = r_ld_inst;
  assign bus.es_load_blk     = r_es_valid & r_res_from_mem;
  assign bus.data_sram_en    = w_sram_en;
  assign bus.data_sram_we    = w_sram_en ? st_mask(r_st_op, w_result[1:0]) : 4'b0000;
  assign bus.data_sram_addr  = w_result;
  assign bus.data_sram_wdata = r_st_op[ST_B] ? {4{r_rkd[7:0]}} :
                               r_st_op[ST_H] ? {2{r_rkd[15:0]}} : r_rkd;
endmodule
